// File: rtl/spi_reg_if.sv
// SPI mode-0 slave bridging an external master to the register file: pins are oversampled on
// sys_clk_i, an 8-bit command selects read/write, and burst words produce single-cycle strobes.
module spi_reg_if #(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  int_clk_i,
    input  logic                  int_mosi_i,
    input  logic                  int_cs_i,
    output logic                  int_miso_o,
    output logic                  int_re_o,
    output logic                  int_we_o,
    output logic [ADDR_WIDTH-1:0] int_addr_o,
    output logic [DATA_WIDTH-1:0] int_data_o,
    input  logic [DATA_WIDTH-1:0] int_data_i,
    output logic                  int_frame_err_o
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam int unsigned SetW = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {StIdle, StCmd, StWrData, StRdData} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                    sclk_prev_q, cs_prev_q;
    logic [SetW-1:0]         settle_q, settle_d;
    logic                    armed_q, armed_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-2:0]   rx_q, rx_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_out_q, addr_out_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    inc_q, inc_d;
    logic                    re_q, re_d, we_q, we_d, err_q, err_d, miso_q, miso_d, ld_q;

    logic sclk_s, cs_s, mosi_s, settled;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    // A frame already in progress at reset release must not look like a fresh CS fall.
    assign cs_fall   = ~cs_s & cs_prev_q & armed_q;
    assign settled   = (settle_q == SetW'(SYNC_STAGES + 1));
    assign settle_d  = settled ? settle_q : settle_q + SetW'(1);
    assign armed_d   = armed_q | (settled & cs_s & cs_prev_q);
    assign cmd_addr  = ADDR_WIDTH'({rx_q[6:0], mosi_s});

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], int_clk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], int_cs_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], int_mosi_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) state_q <= StIdle;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = StIdle;
        end else if (cs_fall) begin
            state_d = StCmd;
        end else if (state_q == StCmd && sclk_rise && cnt_q == CntW'(7)) begin
            state_d = rx_q[6] ? StWrData : StRdData;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = ld_q ? int_data_i : tx_q;
        addr_d     = addr_q;
        addr_out_d = addr_out_q;
        data_out_d = data_out_q;
        inc_d      = inc_q;
        miso_d     = miso_q;
        re_d       = 1'b0;
        we_d       = 1'b0;
        err_d      = 1'b0;
        if (cs_rise) begin
            err_d  = (state_q != StIdle) && (cnt_q != '0);
            cnt_d  = '0;
            rx_d   = '0;
            tx_d   = '0;
            miso_d = 1'b0;
        end else if (cs_fall) begin
            cnt_d  = '0;
            rx_d   = '0;
            tx_d   = '0;
            miso_d = 1'b0;
        end else begin
            case (state_q)
                StCmd: begin
                    if (sclk_rise) begin
                        if (cnt_q == CntW'(7)) begin
                            cnt_d  = '0;
                            rx_d   = '0;
                            inc_d  = rx_q[5];
                            addr_d = cmd_addr;
                            if (!rx_q[6]) begin
                                re_d       = 1'b1;
                                addr_out_d = cmd_addr;
                                addr_d     = cmd_addr + ADDR_WIDTH'(rx_q[5]);
                            end
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                            rx_d  = {rx_q[DATA_WIDTH-3:0], mosi_s};
                        end
                    end
                end
                StWrData: begin
                    if (sclk_rise) begin
                        if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                            cnt_d      = '0;
                            rx_d       = '0;
                            we_d       = 1'b1;
                            data_out_d = {rx_q, mosi_s};
                            addr_out_d = addr_q;
                            addr_d     = addr_q + ADDR_WIDTH'(inc_q);
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                            rx_d  = {rx_q[DATA_WIDTH-3:0], mosi_s};
                        end
                    end
                end
                StRdData: begin
                    if (sclk_rise) begin
                        if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                            // Prefetch the next burst word so it is loaded before the next fall.
                            cnt_d      = '0;
                            re_d       = 1'b1;
                            addr_out_d = addr_q;
                            addr_d     = addr_q + ADDR_WIDTH'(inc_q);
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else if (sclk_fall) begin
                        miso_d = tx_q[DATA_WIDTH-1];
                        tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            addr_q     <= '0;
            addr_out_q <= '0;
            data_out_q <= '0;
            inc_q      <= 1'b0;
            miso_q     <= 1'b0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            ld_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            addr_out_q <= addr_out_d;
            data_out_q <= data_out_d;
            inc_q      <= inc_d;
            miso_q     <= miso_d;
            re_q       <= re_d;
            we_q       <= we_d;
            err_q      <= err_d;
            ld_q       <= re_q;
        end
    end

    assign int_miso_o      = miso_q;
    assign int_re_o        = re_q;
    assign int_we_o        = we_q;
    assign int_addr_o      = addr_out_q;
    assign int_data_o      = data_out_q;
    assign int_frame_err_o = err_q;

endmodule
